// File: rtl/acl_src_filter.sv
// acl_src_filter: snoops the rx byte stream, captures each frame's source address and checks it against a blocklist.
// Latency: verdict (o_verdict_valid/o_fifo_invalid/o_match_idx) is registered, one cycle after the tlast beat.
// Backpressure: none; every valid beat is accepted, and idle (tvalid=0) cycles hold all state.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   i_rxd_tdata/tvalid/tlast      snooped stream (same bus as the FIFO write port)
//   i_rule_wr/idx/addr/en         blocklist entry write, takes effect on the next rising edge
//   o_fifo_invalid, o_verdict_valid, o_match_idx   one-cycle per-frame verdict
//   o_frame_cnt, o_drop_cnt       saturating status counters
module acl_src_filter #(
  parameter int DATA_W      = 8,
  parameter int NUM_RULES   = 4,
  parameter int ADDR_BYTES  = 6,
  parameter int ADDR_OFFSET = 6,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_RULES),
  localparam int AW         = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_rxd_tdata,
  input  logic              i_rxd_tvalid,
  input  logic              i_rxd_tlast,
  input  logic              i_rule_wr,
  input  logic [IDX_W-1:0]  i_rule_idx,
  input  logic [AW-1:0]     i_rule_addr,
  input  logic              i_rule_en,
  output logic              o_fifo_invalid,
  output logic              o_verdict_valid,
  output logic [IDX_W-1:0]  o_match_idx,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  // Byte counter spans 0 .. ADDR_OFFSET+ADDR_BYTES and saturates at the top.
  localparam int BC_TOP    = ADDR_OFFSET + ADDR_BYTES;
  localparam int BCW       = $clog2(BC_TOP + 1);
  localparam int CAP_LAST  = ADDR_OFFSET + ADDR_BYTES - 1;
  // Only meaningful when SKIP is reachable (ADDR_OFFSET >= 2).
  localparam int SKIP_LAST = (ADDR_OFFSET > 0) ? ADDR_OFFSET - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  // Blocklist table
  logic [AW-1:0]        rule_addr_q [NUM_RULES];
  logic [NUM_RULES-1:0] rule_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        rule_addr_q[i] <= '0;
      end
      rule_en_q <= '0;
    end else if (i_rule_wr && (32'(i_rule_idx) < NUM_RULES)) begin
      rule_addr_q[i_rule_idx] <= i_rule_addr;
      rule_en_q[i_rule_idx]   <= i_rule_en;
    end
  end

  // Frame tracking and verdict state
  state_t              state_q, state_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [AW-1:0]       cap_q, cap_d;
  logic                hit_q, hit_d;
  logic [IDX_W-1:0]    hidx_q, hidx_d;
  logic                vld_q, vld_d;
  logic                inv_q, inv_d;
  logic [IDX_W-1:0]    midx_q, midx_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    dcnt_q, dcnt_d;

  logic                capture_now;
  logic                cap_done;
  logic [AW-1:0]       cap_shift;
  logic                hit_c;
  logic [IDX_W-1:0]    hidx_c;
  logic                runt;
  logic                hit_eff;
  logic [IDX_W-1:0]    hidx_eff;

  // With a zero offset the first beat of a frame is already an address byte.
  assign capture_now = i_rxd_tvalid &&
                       ((state_q == CAPTURE) || ((state_q == IDLE) && (ADDR_OFFSET == 0)));
  assign cap_shift   = (cap_q << 8) | AW'(i_rxd_tdata);
  assign cap_done    = capture_now && (bcnt_q == BCW'(CAP_LAST));

  // Compare against the completed address using the table as it stands before
  // this edge, so a write landing on the same edge does not affect this frame.
  // Scanning downward lets the lowest matching index win.
  always_comb begin
    hit_c  = 1'b0;
    hidx_c = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (rule_en_q[i] && (rule_addr_q[i] == cap_shift)) begin
        hit_c  = 1'b1;
        hidx_c = IDX_W'(i);
      end
    end
  end

  // A frame ending on the beat that completes capture is not a runt; it uses
  // the live comparison instead of the stored one.
  assign runt     = (state_q != PAYLOAD) && !cap_done;
  assign hit_eff  = cap_done ? hit_c  : hit_q;
  assign hidx_eff = cap_done ? hidx_c : hidx_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cap_d   = cap_q;
    hit_d   = hit_q;
    hidx_d  = hidx_q;
    vld_d   = 1'b0;
    inv_d   = 1'b0;
    midx_d  = '0;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;

    if (i_rxd_tvalid) begin
      // Clearing on tlast makes the next frame's first beat index 0.
      if (i_rxd_tlast) begin
        bcnt_d = '0;
      end else if (bcnt_q != BCW'(BC_TOP)) begin
        bcnt_d = bcnt_q + BCW'(1);
      end

      if (capture_now) begin
        cap_d = cap_shift;
      end
      if (cap_done) begin
        hit_d  = hit_c;
        hidx_d = hidx_c;
      end

      case (state_q)
        IDLE: begin
          if (ADDR_OFFSET == 0) begin
            state_d = cap_done ? PAYLOAD : CAPTURE;
          end else if (ADDR_OFFSET == 1) begin
            state_d = CAPTURE;
          end else begin
            state_d = SKIP;
          end
        end
        SKIP: begin
          if (bcnt_q == BCW'(SKIP_LAST)) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_done) begin
            state_d = PAYLOAD;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase

      if (i_rxd_tlast) begin
        state_d = IDLE;
        vld_d   = 1'b1;
        inv_d   = runt || hit_eff;
        midx_d  = (!runt && hit_eff) ? hidx_eff : '0;
        if (fcnt_q != {CNT_W{1'b1}}) begin
          fcnt_d = fcnt_q + CNT_W'(1);
        end
        if (inv_d && (dcnt_q != {CNT_W{1'b1}})) begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      cap_q   <= '0;
      hit_q   <= 1'b0;
      hidx_q  <= '0;
      vld_q   <= 1'b0;
      inv_q   <= 1'b0;
      midx_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cap_q   <= cap_d;
      hit_q   <= hit_d;
      hidx_q  <= hidx_d;
      vld_q   <= vld_d;
      inv_q   <= inv_d;
      midx_q  <= midx_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign o_verdict_valid = vld_q;
  assign o_fifo_invalid  = inv_q;
  assign o_match_idx     = midx_q;
  assign o_frame_cnt     = fcnt_q;
  assign o_drop_cnt      = dcnt_q;

endmodule

// File: tb/tb_acl_src_filter.sv
// tb_acl_src_filter: directed frames; expected verdicts are queued at the tlast beat and popped by a monitor.
// Latency: each expectation carries the cycle its pulse must appear in (tlast cycle + 1).
// Backpressure: none on the DUT; the bench drives beats freely, with optional idle gaps.
module tb_acl_src_filter;

  logic        clk;
  logic        rst;
  logic [7:0]  i_rxd_tdata;
  logic        i_rxd_tvalid;
  logic        i_rxd_tlast;
  logic        i_rule_wr;
  logic [1:0]  i_rule_idx;
  logic [47:0] i_rule_addr;
  logic        i_rule_en;
  logic        o_fifo_invalid;
  logic        o_verdict_valid;
  logic [1:0]  o_match_idx;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;

  acl_src_filter dut (
    .clk             (clk),
    .rst             (rst),
    .i_rxd_tdata     (i_rxd_tdata),
    .i_rxd_tvalid    (i_rxd_tvalid),
    .i_rxd_tlast     (i_rxd_tlast),
    .i_rule_wr       (i_rule_wr),
    .i_rule_idx      (i_rule_idx),
    .i_rule_addr     (i_rule_addr),
    .i_rule_en       (i_rule_en),
    .o_fifo_invalid  (o_fifo_invalid),
    .o_verdict_valid (o_verdict_valid),
    .o_match_idx     (o_match_idx),
    .o_frame_cnt     (o_frame_cnt),
    .o_drop_cnt      (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inv;
    logic [1:0]  idx;
    logic [15:0] fc;
    logic [15:0] dc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] m_fc   = '0;
  logic [15:0] m_dc   = '0;

  localparam logic [47:0] ADDR_A  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] ADDR_A2 = 48'h02_00_00_00_00_02;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue one expected verdict; the model counters saturate like the status counters.
  task automatic push_exp(input logic inv, input logic [1:0] idx);
    exp_t e;
    if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    if (inv && (m_dc != 16'hFFFF)) m_dc = m_dc + 16'd1;
    e.inv = inv;
    e.idx = idx;
    e.fc  = m_fc;
    e.dc  = m_dc;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Bytes 6..11 carry the source address MSB-first; other bytes are filler.
  function automatic logic [7:0] frame_byte(input logic [47:0] src, input int i);
    logic [7:0] b;
    if (i >= 6 && i < 12) b = src[8*(11-i) +: 8];
    else                  b = 8'(i) ^ 8'h5A;
    return b;
  endfunction

  task automatic send_frame(input logic [47:0] src, input int len, input bit gaps,
                            input int wr_beat, input logic [1:0] wr_idx, input logic [47:0] wr_addr,
                            input logic exp_inv, input logic [1:0] exp_idx);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_rxd_tvalid = 1'b0;
        i_rxd_tlast  = 1'b0;
        i_rxd_tdata  = 8'hEE;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      i_rxd_tvalid = 1'b1;
      i_rxd_tdata  = frame_byte(src, i);
      i_rxd_tlast  = (i == len - 1);
      if (i == wr_beat) begin
        i_rule_wr   = 1'b1;
        i_rule_idx  = wr_idx;
        i_rule_addr = wr_addr;
        i_rule_en   = 1'b1;
      end
      if (i == len - 1) push_exp(exp_inv, exp_idx);
      @(posedge clk); #1;
      i_rule_wr = 1'b0;
    end
    i_rxd_tvalid = 1'b0;
    i_rxd_tlast  = 1'b0;
  endtask

  task automatic frame(input logic [47:0] src, input int len, input logic exp_inv, input logic [1:0] exp_idx);
    send_frame(src, len, 1'b0, -1, 2'd0, 48'd0, exp_inv, exp_idx);
  endtask

  task automatic wr_rule(input logic [1:0] idx, input logic [47:0] addr, input logic en);
    i_rule_wr   = 1'b1;
    i_rule_idx  = idx;
    i_rule_addr = addr;
    i_rule_en   = en;
    @(posedge clk); #1;
    i_rule_wr   = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_verdict_valid"}, 32'(o_verdict_valid), 32'd0);
    chk({tag, "_fifo_invalid"},  32'(o_fifo_invalid),  32'd0);
    chk({tag, "_match_idx"},     32'(o_match_idx),     32'd0);
    chk({tag, "_frame_cnt"},     32'(o_frame_cnt),     32'd0);
    chk({tag, "_drop_cnt"},      32'(o_drop_cnt),      32'd0);
  endtask

  // Monitor: every verdict pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (o_verdict_valid !== 1'b0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%b required=0 (t=%0t)", o_verdict_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_cycle",  32'(cyc),            32'(mon_e.cyc));
        chk("fifo_invalid", 32'(o_fifo_invalid), 32'(mon_e.inv));
        chk("match_idx",    32'(o_match_idx),    32'(mon_e.idx));
        chk("frame_cnt",    32'(o_frame_cnt),    32'(mon_e.fc));
        chk("drop_cnt",     32'(o_drop_cnt),     32'(mon_e.dc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    i_rxd_tdata  = '0;
    i_rxd_tvalid = 1'b0;
    i_rxd_tlast  = 1'b0;
    i_rule_wr    = 1'b0;
    i_rule_idx   = '0;
    i_rule_addr  = '0;
    i_rule_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // No rules: pass.
    frame(ADDR_A, 20, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;

    // Entry 2 blocks A; then disabled again.
    wr_rule(2'd2, ADDR_A, 1'b1);
    frame(ADDR_A, 20, 1'b1, 2'd2);
    wr_rule(2'd2, ADDR_A, 1'b0);
    frame(ADDR_A, 20, 1'b0, 2'd0);

    // Entries 1 and 3 both match: lowest wins. Last-byte difference passes.
    wr_rule(2'd1, ADDR_A, 1'b1);
    wr_rule(2'd3, ADDR_A, 1'b1);
    frame(ADDR_A, 20, 1'b1, 2'd1);
    frame(ADDR_A2, 20, 1'b0, 2'd0);

    // Runts: truncated inside the address, and a single beat.
    frame(ADDR_A, 9, 1'b1, 2'd0);
    frame(ADDR_A, 1, 1'b1, 2'd0);

    // Capture ends exactly at tlast (12 bytes): not a runt, blocked by entry 1.
    frame(ADDR_A, 12, 1'b1, 2'd1);
    // Capture ends one beat short (11 bytes): runt.
    frame(ADDR_A, 11, 1'b1, 2'd0);

    // Back-to-back: blocked then allowed.
    frame(ADDR_A, 14, 1'b1, 2'd1);
    frame(ADDR_A2, 16, 1'b0, 2'd0);

    // Idle gaps inside the frame do not change the verdict.
    send_frame(ADDR_A, 20, 1'b1, -1, 2'd0, 48'd0, 1'b1, 2'd1);
    send_frame(ADDR_A2, 20, 1'b1, -1, 2'd0, 48'd0, 1'b0, 2'd0);

    // A rule written on the capture-completing beat is invisible to that frame only.
    send_frame(ADDR_A2, 20, 1'b0, 11, 2'd0, ADDR_A2, 1'b0, 2'd0);
    frame(ADDR_A2, 20, 1'b1, 2'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame: everything clears immediately, rules included.
    for (int i = 0; i < 5; i++) begin
      i_rxd_tvalid = 1'b1;
      i_rxd_tdata  = frame_byte(ADDR_A, i);
      i_rxd_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    i_rxd_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    m_fc = '0;
    m_dc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame(ADDR_A, 20, 1'b0, 2'd0);

    // Saturate both counters with single-beat runts, then confirm they hold.
    for (int n = 0; n < 65537; n++) begin
      frame(ADDR_A, 1, 1'b1, 2'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("frame_cnt_saturated", 32'(o_frame_cnt), 32'hFFFF);
    chk("drop_cnt_saturated",  32'(o_drop_cnt),  32'hFFFF);
    chk("pending_expected", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
